unidad_riesgos_adelanto: RTL and testbench
==========================================

# unidad_riesgos_adelanto

Parametrised hazard and forwarding unit for the five-stage pipeline, driving the EX-stage operand muxes and the IF/ID hold and ID/EX bubble controls. It generalises operand forwarding to configurable register-address width with strict MEM-over-WB priority. It adds load-use stall detection and a down-counting scoreboard for the multi-cycle multiply/divide unit guarding HI/LO. A saturating stall-cycle counter is provided for performance measurement.

## Interface
- REG_AW, 5, register address width
- MD_LAT, 4, multiply/divide latency in cycles (≥1)
- STALL_CW, 16, width of stall-cycle counter
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- id_rs, id_rt  in  REG_AW each  source registers of instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads that source
- id_uses_hilo  in  1  ID instruction is mfhi/mflo
- id_is_muldiv  in  1  ID instruction is mult/div
- ex_rs, ex_rt  in  REG_AW each  source registers of instruction in EX
- ex_rd  in  REG_AW  destination of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_muldiv_start  in  1  mult/div in EX, issuing this cycle
- mem_rd, wb_rd  in  REG_AW each  destinations in MEM, WB
- mem_reg_write, wb_reg_write  in  1 each  register write enables in MEM, WB
- flush  in  1  branch/jump taken; ID instruction squashed
- stall_clr  in  1  synchronous clear of stall counter
- fwd_a, fwd_b  out  2 each  operand select: 00 register file, 01 WB, 10 MEM
- stall_if  out  1  hold PC and IF/ID
- bubble_ex  out  1  load NOP into ID/EX
- md_busy  out  1  scoreboard count nonzero
- stall_count  out  STALL_CW  saturating count of stalled cycles

## Operation
- Forwarding (per operand; A uses ex_rs, B uses ex_rt; src denotes that register):
  - 10 if mem_reg_write && mem_rd==src && mem_rd!=0
  - else 01 if wb_reg_write && wb_rd==src && wb_rd!=0
  - else 00. MEM always wins over WB when both match.
- Load-use: lu = ex_mem_read && ex_rd!=0 && ((id_uses_rs && ex_rd==id_rs) || (id_uses_rt && ex_rd==id_rt)). Unused sources never stall.
- Scoreboard: register md_cnt, width clog2(MD_LAT+1).
  - ex_muldiv_start loads MD_LAT.
  - else nonzero decrements by 1.
  - md_busy = md_cnt!=0.
- HI/LO hazard: hh = (id_uses_hilo || id_is_muldiv) && (ex_muldiv_start || md_busy).
- stall_if = bubble_ex = (lu || hh) && !flush. flush suppresses stall; the squashed instruction needs no interlock.
- flush does not affect md_cnt. An issued mult/div always completes.
- ex_muldiv_start while md_busy (illegal but tolerated): reload MD_LAT.
- stall_count: stall_clr → 0. Else +1 on each cycle stall_if=1, saturating at all-ones. stall_clr wins over a simultaneous increment.

## Timing
- fwd_a, fwd_b, stall_if, bubble_ex combinational, zero latency, from current inputs and md_cnt.
- md_cnt, stall_count update on the rising clk edge.
- reset_n low: md_cnt=0, stall_count=0 immediately. With all inputs 0, outputs are fwd_a=fwd_b=00, stall_if=bubble_ex=md_busy=0.
- Reset asserted mid-multiply aborts the scoreboard (md_busy=0 next evaluation).
- Load-use stall lasts exactly 1 cycle. The load then moves to MEM and the dependent instruction receives fwd=10 in EX next cycle.
- mfhi directly behind mult: start cycle plus MD_LAT busy cycles give MD_LAT+1 stall cycles. mfhi enters EX in the cycle after md_cnt reaches 0.
- MD_LAT=1: md_busy high for exactly one cycle after start.

## Test plan
- mem_rd=wb_rd=ex_rs=ex_rt=5, both reg_write=1 → fwd_a=fwd_b=10. Clear mem_reg_write → 01. Set all rd=0 → 00.
- ex_mem_read=1, ex_rd=8, id_rt=8, id_uses_rt=1 → stall_if=bubble_ex=1 for one cycle. Same with id_uses_rt=0 → no stall.
- MD_LAT=4: ex_muldiv_start pulse, id_uses_hilo held 1 → stall_if high 5 consecutive cycles, md_busy high cycles 2–5, stall_count=5 afterwards.
- lu condition with flush=1 → stall_if=0, stall_count unchanged.
- reset_n dropped while md_cnt=3 → md_busy=0 and stall_count=0 asynchronously, before the next edge.
- STALL_CW=4, stall held 20 cycles → stall_count saturates at 15. stall_clr together with stall → 0.

Source files
------------

// File: rtl/unidad_riesgos_adelanto.sv
// Hazard and forwarding unit for the five-stage pipeline: EX operand forwarding,
// load-use and HI/LO interlocks, multiply/divide scoreboard and a stall-cycle counter.
module unidad_riesgos_adelanto #(
    parameter int REG_AW   = 5,
    parameter int MD_LAT   = 4,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic                id_uses_hilo,
    input  logic                id_is_muldiv,
    input  logic [REG_AW-1:0]   ex_rs,
    input  logic [REG_AW-1:0]   ex_rt,
    input  logic [REG_AW-1:0]   ex_rd,
    input  logic                ex_mem_read,
    input  logic                ex_muldiv_start,
    input  logic [REG_AW-1:0]   mem_rd,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic                mem_reg_write,
    input  logic                wb_reg_write,
    input  logic                flush,
    input  logic                stall_clr,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                stall_if,
    output logic                bubble_ex,
    output logic                md_busy,
    output logic [STALL_CW-1:0] stall_count
);

    localparam int MD_W = $clog2(MD_LAT + 1);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT);

    logic [MD_W-1:0]     md_cnt_q, md_cnt_d;
    logic [STALL_CW-1:0] stall_count_q, stall_count_d;
    logic [1:0]          fwd_sel [2];
    logic                load_use;
    logic                hilo_hazard;
    logic                stall;

    // Operand 0 is A (ex_rs), operand 1 is B (ex_rt); MEM has priority over WB.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [REG_AW-1:0] src;
        assign src = (gi == 0) ? ex_rs : ex_rt;

        always_comb begin
            fwd_sel[gi] = 2'b00;
            if (mem_reg_write && (mem_rd == src) && (mem_rd != '0)) begin
                fwd_sel[gi] = 2'b10;
            end else if (wb_reg_write && (wb_rd == src) && (wb_rd != '0)) begin
                fwd_sel[gi] = 2'b01;
            end
        end
    end

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    always_comb begin
        load_use      = ex_mem_read && (ex_rd != '0) &&
                        ((id_uses_rs && (ex_rd == id_rs)) ||
                         (id_uses_rt && (ex_rd == id_rt)));
        hilo_hazard   = (id_uses_hilo || id_is_muldiv) &&
                        (ex_muldiv_start || (md_cnt_q != '0));
        // A squashed ID instruction never needs an interlock.
        stall         = (load_use || hilo_hazard) && !flush;

        md_cnt_d = md_cnt_q;
        if (ex_muldiv_start) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end

        stall_count_d = stall_count_q;
        if (stall_clr) begin
            stall_count_d = '0;
        end else if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_q      <= '0;
            stall_count_q <= '0;
        end else begin
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_if    = stall;
    assign bubble_ex   = stall;
    assign md_busy     = (md_cnt_q != '0);
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_unidad_riesgos_adelanto.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and
// compares them against a default instance and a 4-bit stall-counter instance.
module tb_unidad_riesgos_adelanto;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs, id_uses_rt, id_uses_hilo, id_is_muldiv;
    logic       ex_mem_read, ex_muldiv_start, mem_reg_write, wb_reg_write;
    logic       flush, stall_clr;

    logic [1:0]  fwd_a, fwd_b, fwd_a4, fwd_b4;
    logic        stall_if, bubble_ex, md_busy, stall_if4, bubble_ex4, md_busy4;
    logic [15:0] stall_count;
    logic [3:0]  stall_count4;

    always #5 clk = ~clk;

    unidad_riesgos_adelanto dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_uses_hilo(id_uses_hilo), .id_is_muldiv(id_is_muldiv),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_muldiv_start(ex_muldiv_start), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .flush(flush), .stall_clr(stall_clr),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if(stall_if), .bubble_ex(bubble_ex),
        .md_busy(md_busy), .stall_count(stall_count)
    );

    unidad_riesgos_adelanto #(.STALL_CW(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_uses_hilo(id_uses_hilo), .id_is_muldiv(id_is_muldiv),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_muldiv_start(ex_muldiv_start), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .flush(flush), .stall_clr(stall_clr),
        .fwd_a(fwd_a4), .fwd_b(fwd_b4), .stall_if(stall_if4), .bubble_ex(bubble_ex4),
        .md_busy(md_busy4), .stall_count(stall_count4)
    );

    typedef struct {
        string      name;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       busy;
        int         cnt;
        int         cnt4;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    event probe_ev;

    task automatic cmp(input string name, input string field, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_mis++;
            $display("FAIL %s.%s got %0d want %0d", name, field, got, want);
        end
    endtask

    // Monitor: outputs are combinational/registered and always present, so every
    // pending expectation is checked on the falling edge or on an explicit probe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or probe_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("check %s: fwd_a=%0d fwd_b=%0d stall=%0d bubble=%0d busy=%0d cnt=%0d cnt4=%0d",
                         e.name, fwd_a, fwd_b, stall_if, bubble_ex, md_busy, stall_count, stall_count4);
                cmp(e.name, "fwd_a",       int'(fwd_a),        int'(e.fa));
                cmp(e.name, "fwd_b",       int'(fwd_b),        int'(e.fb));
                cmp(e.name, "stall_if",    int'(stall_if),     int'(e.st));
                cmp(e.name, "bubble_ex",   int'(bubble_ex),    int'(e.st));
                cmp(e.name, "md_busy",     int'(md_busy),      int'(e.busy));
                cmp(e.name, "stall_count", int'(stall_count),  e.cnt);
                cmp(e.name, "stall_cnt4",  int'(stall_count4), e.cnt4);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [1:0] fa, input logic [1:0] fb,
                              input logic st, input logic busy, input int cnt, input int cnt4);
        exp_t e;
        e.name = name; e.fa = fa; e.fb = fb; e.st = st; e.busy = busy;
        e.cnt = cnt; e.cnt4 = cnt4;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0; id_is_muldiv = 0;
        ex_mem_read = 0; ex_muldiv_start = 0; mem_reg_write = 0; wb_reg_write = 0;
        flush = 0; stall_clr = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();

        cyc(); expect_out("reset", 0, 0, 0, 0, 0, 0);

        // Forwarding priority
        cyc(); reset_n = 1'b1;
        ex_rs = 5; ex_rt = 5; mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1;
        expect_out("fwd_mem", 2, 2, 0, 0, 0, 0);
        cyc(); mem_reg_write = 0;
        expect_out("fwd_wb", 1, 1, 0, 0, 0, 0);
        cyc(); mem_rd = 0; wb_rd = 0; mem_reg_write = 1; wb_reg_write = 1; ex_rs = 0; ex_rt = 0;
        expect_out("fwd_r0", 0, 0, 0, 0, 0, 0);
        cyc(); ex_rs = 5; ex_rt = 6; mem_rd = 5; wb_rd = 6;
        expect_out("fwd_split", 2, 1, 0, 0, 0, 0);

        // Load-use on rt, then forwarding from MEM
        cyc(); clear_inputs();
        ex_mem_read = 1; ex_rd = 8; id_rt = 8; id_uses_rt = 1;
        expect_out("lu_rt", 0, 0, 1, 0, 0, 0);
        cyc(); clear_inputs();
        mem_rd = 8; mem_reg_write = 1; ex_rt = 8;
        expect_out("lu_fwd", 0, 2, 0, 0, 1, 1);
        cyc(); clear_inputs();
        ex_mem_read = 1; ex_rd = 8; id_rt = 8; id_uses_rt = 0;
        expect_out("lu_unused", 0, 0, 0, 0, 1, 1);
        cyc(); id_uses_rt = 1; flush = 1;
        expect_out("lu_flush", 0, 0, 0, 0, 1, 1);
        cyc(); clear_inputs();
        ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1;
        expect_out("lu_rs", 0, 0, 1, 0, 1, 1);
        cyc(); clear_inputs(); stall_clr = 1;
        expect_out("idle_clr", 0, 0, 0, 0, 2, 2);

        // mfhi directly behind mult: MD_LAT+1 stall cycles
        cyc(); stall_clr = 0; ex_muldiv_start = 1; id_uses_hilo = 1;
        expect_out("md_start", 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(); ex_muldiv_start = 0;
            expect_out($sformatf("md_wait%0d", k), 0, 0, 1, 1, k, k);
        end
        cyc();
        expect_out("md_done", 0, 0, 0, 0, 5, 5);

        // mult/div in ID behind an issuing mult, then reset mid-operation
        cyc(); id_uses_hilo = 0; id_is_muldiv = 1; ex_muldiv_start = 1;
        expect_out("md_md", 0, 0, 1, 0, 5, 5);
        cyc(); id_is_muldiv = 0; ex_muldiv_start = 0;
        expect_out("md_busy4", 0, 0, 0, 1, 6, 6);
        cyc();
        expect_out("md_busy3", 0, 0, 0, 1, 6, 6);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        expect_out("async_rst", 0, 0, 0, 0, 0, 0);
        ->probe_ev;
        cyc(); reset_n = 1'b1;
        expect_out("post_rst", 0, 0, 0, 0, 0, 0);

        // Saturation of the 4-bit counter; clear wins over increment
        for (int k = 0; k <= 20; k++) begin
            cyc();
            ex_mem_read = 1; ex_rd = 8; id_rt = 8; id_uses_rt = 1;
            stall_clr = (k == 20);
            expect_out($sformatf("sat%0d", k), 0, 0, 1, 0, k, (k > 15) ? 15 : k);
        end
        cyc(); clear_inputs();
        expect_out("clr_wins", 0, 0, 0, 0, 0, 0);

        @(negedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

endmodule
